counter_stimulus_sequencer: RTL and testbench

//  Synthesizable stimulus generator that drives the counter DUT (enable, mode, D, DUT reset).

---
 rtl/counter_stimulus_sequencer_pkg.sv | 35 +++
 rtl/counter_stimulus_sequencer_phase_timer.sv | 39 +++
 rtl/counter_stimulus_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_counter_stimulus_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/counter_stimulus_sequencer_pkg.sv
// rtl/counter_stimulus_sequencer_pkg.sv - shared levels, DUT mode encodings and sequencer state codes
package counter_stimulus_sequencer_pkg;

  localparam logic ALTO = 1'b1;
  localparam logic BAJO = 1'b0;

  // Counter DUT mode encodings
  localparam logic [1:0] CUENTA_MAS_UNO   = 2'b00;
  localparam logic [1:0] CUENTA_MENOS_UNO = 2'b01;
  localparam logic [1:0] CUENTA_TRES_TRES = 2'b10;
  localparam logic [1:0] CARGA_D          = 2'b11;

  typedef enum logic [2:0] {
    SEQ_IDLE    = 3'd0,
    SEQ_RST     = 3'd1,
    SEQ_LOAD    = 3'd2,
    SEQ_UP      = 3'd3,
    SEQ_DOWN    = 3'd4,
    SEQ_THREE   = 3'd5,
    SEQ_DISABLE = 3'd6,
    SEQ_DONE    = 3'd7
  } seq_state_e;

  // Successor of a handshake-gated phase; used for both handshake and silent timeout
  function automatic seq_state_e next_phase(input seq_state_e s);
    case (s)
      SEQ_LOAD:  return SEQ_UP;
      SEQ_UP:    return SEQ_DOWN;
      SEQ_DOWN:  return SEQ_THREE;
      SEQ_THREE: return SEQ_DISABLE;
      default:   return SEQ_DONE;
    endcase
  endfunction

endpackage

// File: rtl/counter_stimulus_sequencer_phase_timer.sv
// rtl/counter_stimulus_sequencer_phase_timer.sv - saturating per-phase cycle counter with terminal flag
module counter_stimulus_sequencer_phase_timer #(
  parameter int PHASE_CYCLES = 20,
  parameter int CW           = $clog2(PHASE_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Clear wins over counting; the count stops at PHASE_CYCLES so it never wraps
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CW'(PHASE_CYCLES))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count    = cnt_q;
  assign terminal = (cnt_q == CW'(PHASE_CYCLES - 1));

endmodule

// File: rtl/counter_stimulus_sequencer.sv
// rtl/counter_stimulus_sequencer.sv - counter DUT stimulus sequencer; define REQUIRE_RCO_EN to make timeouts errors
module counter_stimulus_sequencer
  import counter_stimulus_sequencer_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int LOAD_VALUE   = 5,
  parameter int PHASE_CYCLES = 20,
  parameter int RESET_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             rco,
  input  logic             load,
  output logic             dut_reset,
  output logic             enable,
  output logic [1:0]       mode,
  output logic [WIDTH-1:0] D,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [2:0]       phase
);

  localparam int               CW     = $clog2(PHASE_CYCLES + 1);
  localparam logic [WIDTH-1:0] LOAD_D = WIDTH'(LOAD_VALUE);

  seq_state_e       state_q, state_d;
  logic             dut_reset_q, dut_reset_d;
  logic             enable_q, enable_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             handshake;
  logic [CW-1:0]    cnt;
  logic             cnt_terminal;

  counter_stimulus_sequencer_phase_timer #(
    .PHASE_CYCLES (PHASE_CYCLES),
    .CW           (CW)
  ) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (state_d != state_q),
    .enable   (state_q != SEQ_IDLE),
    .count    (cnt),
    .terminal (cnt_terminal)
  );

  // Next state and sticky error; a handshake always beats a same-cycle timeout
  always_comb begin
    state_d   = state_q;
    error_d   = error_q;
    handshake = BAJO;
    case (state_q)
      SEQ_IDLE: begin
        if (start) begin
          state_d = SEQ_RST;
          error_d = BAJO;
        end
      end
      SEQ_RST: begin
        if (cnt == CW'(RESET_CYCLES - 1)) state_d = SEQ_LOAD;
      end
      SEQ_LOAD, SEQ_UP, SEQ_DOWN, SEQ_THREE: begin
        handshake = (state_q == SEQ_LOAD) ? load : rco;
        if (handshake) begin
          state_d = next_phase(state_q);
        end else if (cnt_terminal) begin
`ifdef REQUIRE_RCO_EN
          state_d = SEQ_DONE;
          error_d = ALTO;
`else
          state_d = next_phase(state_q);
`endif
        end
      end
      SEQ_DISABLE: begin
        if (cnt == CW'(1)) state_d = SEQ_DONE;
      end
      SEQ_DONE: begin
        if (start) begin
          state_d = SEQ_RST;
          error_d = BAJO;
        end
      end
    endcase
  end

  // Output values for the state being entered, so they register alongside the state
  always_comb begin
    dut_reset_d = ALTO;
    enable_d    = BAJO;
    mode_d      = CUENTA_MAS_UNO;
    d_d         = '0;
    busy_d      = BAJO;
    done_d      = BAJO;
    case (state_d)
      SEQ_IDLE: begin
      end
      SEQ_RST: begin
        enable_d = ALTO;
        busy_d   = ALTO;
      end
      SEQ_LOAD: begin
        dut_reset_d = BAJO;
        enable_d    = ALTO;
        mode_d      = CARGA_D;
        d_d         = LOAD_D;
        busy_d      = ALTO;
      end
      SEQ_UP: begin
        dut_reset_d = BAJO;
        enable_d    = ALTO;
        mode_d      = CUENTA_MAS_UNO;
        d_d         = LOAD_D;
        busy_d      = ALTO;
      end
      SEQ_DOWN: begin
        dut_reset_d = BAJO;
        enable_d    = ALTO;
        mode_d      = CUENTA_MENOS_UNO;
        d_d         = LOAD_D;
        busy_d      = ALTO;
      end
      SEQ_THREE: begin
        dut_reset_d = BAJO;
        enable_d    = ALTO;
        mode_d      = CUENTA_TRES_TRES;
        d_d         = LOAD_D;
        busy_d      = ALTO;
      end
      SEQ_DISABLE: begin
        dut_reset_d = BAJO;
        mode_d      = CUENTA_TRES_TRES;
        d_d         = LOAD_D;
        busy_d      = ALTO;
      end
      SEQ_DONE: begin
        mode_d = CUENTA_TRES_TRES;
        d_d    = LOAD_D;
        done_d = ALTO;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SEQ_IDLE;
      dut_reset_q <= ALTO;
      enable_q    <= BAJO;
      mode_q      <= CUENTA_MAS_UNO;
      d_q         <= '0;
      busy_q      <= BAJO;
      done_q      <= BAJO;
      error_q     <= BAJO;
    end else begin
      state_q     <= state_d;
      dut_reset_q <= dut_reset_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      d_q         <= d_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign dut_reset = dut_reset_q;
  assign enable    = enable_q;
  assign mode      = mode_q;
  assign D         = d_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign phase     = state_q;

endmodule

// File: tb/tb_counter_stimulus_sequencer.sv
// tb/tb_counter_stimulus_sequencer.sv - scoreboard bench with a phase/age reference model
module tb_counter_stimulus_sequencer;

  localparam int WIDTH        = 4;
  localparam int LOAD_VALUE   = 5;
  localparam int PHASE_CYCLES = 20;
  localparam int RESET_CYCLES = 2;
`ifdef REQUIRE_RCO_EN
  localparam bit REQ = 1'b1;
`else
  localparam bit REQ = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset, start, rco, load;
  logic             dut_reset, enable, busy, done, error;
  logic [1:0]       mode;
  logic [WIDTH-1:0] D;
  logic [2:0]       phase;

  always #5 clk = ~clk;

  counter_stimulus_sequencer #(
    .WIDTH        (WIDTH),
    .LOAD_VALUE   (LOAD_VALUE),
    .PHASE_CYCLES (PHASE_CYCLES),
    .RESET_CYCLES (RESET_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rco       (rco),
    .load      (load),
    .dut_reset (dut_reset),
    .enable    (enable),
    .mode      (mode),
    .D         (D),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .phase     (phase)
  );

  typedef struct {
    logic             dut_reset;
    logic             enable;
    logic [1:0]       mode;
    logic             chk_mode;
    logic [WIDTH-1:0] d;
    logic             chk_d;
    logic             busy;
    logic             done;
    logic             error;
    logic [2:0]       phase;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: phase number, cycles spent in it, sticky error
  int   m_st  = 0;
  int   m_age = 0;
  logic m_err = 1'b0;

  // Mode expected while sitting in each phase (0..7)
  logic [1:0] mode_tbl [8] = '{2'b00, 2'b00, 2'b11, 2'b00, 2'b01, 2'b10, 2'b10, 2'b10};

  task automatic model_step(input logic r, input logic s, input logic rc, input logic ld);
    int nxt;
    if (r) begin
      m_st = 0; m_age = 0; m_err = 1'b0;
    end else begin
      nxt = m_st;
      if (m_st == 0 || m_st == 7) begin
        if (s) begin nxt = 1; m_err = 1'b0; end
      end else if (m_st == 1) begin
        if (m_age == RESET_CYCLES - 1) nxt = 2;
      end else if (m_st >= 2 && m_st <= 5) begin
        if ((m_st == 2) ? ld : rc) nxt = m_st + 1;
        else if (m_age == PHASE_CYCLES - 1) begin
          if (REQ) begin nxt = 7; m_err = 1'b1; end
          else nxt = m_st + 1;
        end
      end else begin
        if (m_age == 1) nxt = 7;
      end
      if (nxt != m_st) m_age = 0;
      else if (m_age < PHASE_CYCLES) m_age = m_age + 1;
      m_st = nxt;
    end
  endtask

  function automatic exp_t expect_of(input int st, input logic err);
    exp_t e;
    e.dut_reset = (st == 0 || st == 1 || st == 7);
    e.enable    = (st >= 1 && st <= 5);
    e.mode      = mode_tbl[st];
    e.chk_mode  = (st <= 6);
    e.d         = (st == 2) ? WIDTH'(LOAD_VALUE) : '0;
    e.chk_d     = (st == 0 || st == 2);
    e.busy      = (st >= 1 && st <= 6);
    e.done      = (st == 7);
    e.error     = err;
    e.phase     = 3'(st);
    return e;
  endfunction

  task automatic cyc(input logic r, input logic s, input logic rc, input logic ld);
    @(negedge clk);
    #1;
    reset = r; start = s; rco = rc; load = ld;
    model_step(r, s, rc, ld);
    exp_q.push_back(expect_of(m_st, m_err));
  endtask

  // Monitor: after each active edge compare the registered outputs to the oldest expectation
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ok = (dut_reset === e.dut_reset) && (enable === e.enable) &&
             (!e.chk_mode || mode === e.mode) && (!e.chk_d || D === e.d) &&
             (busy === e.busy) && (done === e.done) && (error === e.error) &&
             (phase === e.phase);
        checks++;
        if (ok) passes++;
        else $display("FAIL outputs t=%0t: got rst=%b en=%b mode=%b D=%0d busy=%b done=%b err=%b phase=%0d; want rst=%b en=%b mode=%b(%b) D=%0d(%b) busy=%b done=%b err=%b phase=%0d",
                      $time, dut_reset, enable, mode, D, busy, done, error, phase,
                      e.dut_reset, e.enable, e.mode, e.chk_mode, e.d, e.chk_d, e.busy, e.done, e.error, e.phase);
      end
    end
  end

  int lp_tbl [6] = '{30, 0, 30, 100, 50, 10};
  int rp_tbl [6] = '{10, 10, 0, 100, 5, 50};

  initial begin
    reset = 1'b1; start = 1'b0; rco = 1'b0; load = 1'b0;
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // Well-behaved DUT: every handshake arrives on the fourth cycle of its phase
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 80 && m_st != 7; k++) cyc(1'b0, 1'b0, m_age == 3, m_age == 3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

    // rco stuck low: UP times out
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 150 && m_st != 7; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);

    // load stuck low: LOAD times out
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 150 && m_st != 7; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0);

    // start ignored in UP, then reset mid-UP, then restart from IDLE
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 40 && m_st != 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // Randomised handshake profiles with occasional stray start and reset
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 250; k++) begin
        logic r, s, rc, ld;
        r  = ($urandom_range(0, 199) == 0);
        if (m_st == 0 || m_st == 7) s = ($urandom_range(0, 7) == 0);
        else                        s = ($urandom_range(0, 29) == 0);
        rc = (int'($urandom_range(0, 99)) < rp_tbl[p]);
        ld = (int'($urandom_range(0, 99)) < lp_tbl[p]);
        cyc(r, s, rc, ld);
      end
    end

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
